// File: rtl/cnn_pkg.sv
// cnn_pkg: definitions shared by the CNN datapath blocks (FIFO array,
// skew reader, PE array): read-sequencer state encodings, default array
// geometry and the FIFO read latency.
package cnn_pkg;

   // Read-sequencer states; encodings are fixed so other blocks and
   // debug tooling can decode them.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Default geometry, shared with the FIFO array and the PE array.
   localparam int DEF_DATA_SIZE  = 16;
   localparam int DEF_ARRAY_SIZE = 9;

   // Cycles from a FIFO read enable to its word on the FIFO output bus.
   localparam int FIFO_RD_LATENCY = 1;

endpackage

// File: rtl/fifo_skew_reader.sv
// fifo_skew_reader: read-side sequencer for the lane FIFO array. Drains
// len words per lane, lane i trailing lane 0 by i steps, to build the
// diagonal wavefront for the systolic PE array. Registers the returned
// words and tags each lane with a valid bit.
//
// Build option: define FIFO_SKEW_READER_ZERO_PAD_EN to force each lane's
// data_out to 0 whenever its data_valid is low; otherwise data_out holds
// the last valid word.
module fifo_skew_reader
   import cnn_pkg::*;
#(
   parameter int DATA_SIZE  = DEF_DATA_SIZE,
   parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
   parameter int LEN_W      = 16
) (
   input  logic                            r_clk,
   input  logic                            rclear,
   input  logic                            start,
   input  logic [LEN_W-1:0]                len,
   input  logic                            hold,
   input  logic [ARRAY_SIZE-1:0]           empty,
   input  logic [DATA_SIZE*ARRAY_SIZE-1:0] fifo_data,
   output logic [ARRAY_SIZE-1:0]           r_en,
   output logic [DATA_SIZE*ARRAY_SIZE-1:0] data_out,
   output logic [ARRAY_SIZE-1:0]           data_valid,
   output logic                            busy,
   output logic                            done
);

   // Step counter and length are one bit wider than len so that
   // len + ARRAY_SIZE - 1 never wraps, even at the maximum len.
   localparam int KW = LEN_W + 1;

   // Wait after the last issue: FIFO latency plus the output register.
   localparam int DRAIN_CYCLES = FIFO_RD_LATENCY + 1;

   // The final step index is len + ARRAY_SIZE - 2.
   localparam logic [KW-1:0] LAST_OFS = KW'(ARRAY_SIZE - 2);

   state_t                state;
   logic [KW-1:0]         k;
   logic [KW-1:0]         len_q;
   logic [KW-1:0]         last_k;
   logic [1:0]            drain_cnt;
   logic [ARRAY_SIZE-1:0] active;
   logic [ARRAY_SIZE-1:0] rd_pend;
   logic                  step;

   assign last_k = len_q + LAST_OFS;

   // A step fires only when every lane inside its window can read, so the
   // whole wavefront advances or stalls together and alignment is kept.
   // NOTE: r_en is a pure continuous assignment of state, k, empty and
   // hold -- every bit always has a value, so no latch can be inferred.
   assign step = (state == ST_RUN) && !hold && ((active & empty) == '0);
   assign r_en = step ? active : '0;

   // Sequencer FSM: start/length capture, step counting, drain and done.
   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge r_clk or posedge rclear) begin
      if (rclear) begin
         state     <= ST_IDLE;
         k         <= '0;
         len_q     <= '0;
         drain_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  len_q <= KW'(len);
                  k     <= '0;
                  busy  <= 1'b1;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (len_q == '0) begin
                  // Empty transfer: no lane ever enters its window.
                  state <= ST_DONE;
                  done  <= 1'b1;
               end else if (step) begin
                  k <= k + KW'(1);
                  if (k == last_k) begin
                     drain_cnt <= '0;
                     state     <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + 2'd1;
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Read pipeline: a read issued in cycle c returns data in c+1, which is
   // registered and flagged valid in c+2.
   always_ff @(posedge r_clk or posedge rclear) begin
      if (rclear) begin
         rd_pend    <= '0;
         data_valid <= '0;
      end else begin
         rd_pend    <= r_en;
         data_valid <= rd_pend;
      end
   end

   for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
      localparam logic [KW-1:0] LANE_IDX = KW'(i);

      logic [DATA_SIZE-1:0] word_q;

      // Lane i reads while i <= k < i + len.
      assign active[i] = (k >= LANE_IDX) && (k < LANE_IDX + len_q);

      // Lane output register: capture the returning FIFO word.
      // NOTE: the data registers are reset too, since data_out must read
      // 0 after rclear; they are flops here, not a memory array.
      always_ff @(posedge r_clk or posedge rclear) begin
         if (rclear) begin
            word_q <= '0;
         end else begin
`ifdef FIFO_SKEW_READER_ZERO_PAD_EN
            word_q <= rd_pend[i] ? fifo_data[i*DATA_SIZE +: DATA_SIZE] : '0;
`else
            if (rd_pend[i]) begin
               word_q <= fifo_data[i*DATA_SIZE +: DATA_SIZE];
            end
`endif
         end
      end

      assign data_out[i*DATA_SIZE +: DATA_SIZE] = word_q;
   end

endmodule
